// File: rtl/aer_rx_decoder.sv
// AER receiver: synchronises the sender's four-phase request and acknowledges it.
// Accepted addresses go into a first-word-fall-through FIFO that drives a valid/ready stream.
module aer_rx_decoder #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aer_req,
    input  logic [ADDR_W-1:0] aer_addr,
    output logic              aer_ack,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [LW-1:0]     fifo_level,
    output logic [CNT_W-1:0]  ev_count,
    output logic              err_timeout
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1
    } state_t;

    state_t            state;
    logic              req_meta;
    logic              req_s;
    logic [TW-1:0]     tmo;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full_c;
    logic              push_c;
    logic              pop_c;

    // Fullness uses the registered level, so a pop in the same cycle cannot free a slot early.
    assign full_c   = (fifo_level == LW'(DEPTH));
    assign push_c   = (state == IDLE) && req_s && !full_c;
    assign ev_valid = (fifo_level != '0);
    assign pop_c    = ev_valid && ev_ready;
    assign ev_addr  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_meta    <= 1'b0;
            req_s       <= 1'b0;
            aer_ack     <= 1'b0;
            tmo         <= '0;
            err_timeout <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            ev_count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            req_meta <= aer_req;
            req_s    <= req_meta;

            // Handshake: ack only after an accepted push, release only after req_s drops.
            case (state)
                IDLE: begin
                    aer_ack <= 1'b0;
                    tmo     <= '0;
                    if (push_c) begin
                        aer_ack <= 1'b1;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!req_s) begin
                        aer_ack <= 1'b0;
                        tmo     <= '0;
                        state   <= IDLE;
                    end else begin
                        aer_ack <= 1'b1;
                        if (tmo != TW'(TIMEOUT)) begin
                            tmo <= tmo + TW'(1);
                        end
                        if ((TIMEOUT != 0) && ((tmo + TW'(1)) == TW'(TIMEOUT))) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    aer_ack <= 1'b0;
                    tmo     <= '0;
                    state   <= IDLE;
                end
            endcase

            if (push_c) begin
                mem[wr_ptr] <= aer_addr;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= fifo_level + LW'(push_c) - LW'(pop_c);

            if (push_c && (ev_count != {CNT_W{1'b1}})) begin
                ev_count <= ev_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aer_rx_decoder.sv
// Directed bench for aer_rx_decoder: handshake latency, back-pressure, same-cycle push/pop,
// timeout, mid-handshake reset and counter saturation.
module tb_aer_rx_decoder;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned LW      = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              aer_req;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ack;
    logic              ev_valid;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_addr;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  ev_count;
    logic              err_timeout;

    int errors = 0;
    int checks = 0;

    aer_rx_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aer_req    (aer_req),
        .aer_addr   (aer_addr),
        .aer_ack    (aer_ack),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .fifo_level (fifo_level),
        .ev_count   (ev_count),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        aer_req  = 1'b0;
        aer_addr = '0;
        ev_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Full four-phase transaction with bounded waits on both ack edges.
    task automatic send_event(input logic [ADDR_W-1:0] a);
        int n;
        aer_addr = a;
        aer_req  = 1'b1;
        n = 0;
        while (!aer_ack && n < 12) begin
            tick();
            n++;
        end
        check("send_ack_rise", 32'(aer_ack), 32'd1);
        aer_req = 1'b0;
        n = 0;
        while (aer_ack && n < 12) begin
            tick();
            n++;
        end
        check("send_ack_fall", 32'(aer_ack), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        aer_req  = 1'b0;
        aer_addr = '0;
        ev_ready = 1'b0;
        tick();
        tick();
        check("rst_ack",   32'(aer_ack),     32'd0);
        check("rst_valid", 32'(ev_valid),    32'd0);
        check("rst_addr",  32'(ev_addr),     32'd0);
        check("rst_level", 32'(fifo_level),  32'd0);
        check("rst_count", 32'(ev_count),    32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
        reset = 1'b1;
        tick();

        // Single event: ack and ev_valid on the third edge, ev_valid for one clock.
        ev_ready = 1'b1;
        aer_addr = 3'd2;
        aer_req  = 1'b1;
        tick();
        check("se_ack_e1", 32'(aer_ack), 32'd0);
        tick();
        check("se_ack_e2", 32'(aer_ack), 32'd0);
        tick();
        check("se_ack_e3",   32'(aer_ack),  32'd1);
        check("se_valid_e3", 32'(ev_valid), 32'd1);
        check("se_addr_e3",  32'(ev_addr),  32'd2);
        check("se_count",    32'(ev_count), 32'd1);
        tick();
        check("se_valid_e4", 32'(ev_valid), 32'd0);
        repeat (6) tick();
        aer_req = 1'b0;
        tick();
        tick();
        check("se_ack_hold", 32'(aer_ack), 32'd1);
        tick();
        check("se_ack_drop", 32'(aer_ack), 32'd0);

        // Back-pressure: four fill the FIFO, the fifth stalls until space appears.
        do_reset();
        for (int i = 0; i < 4; i++) send_event(ADDR_W'(i));
        check("bp_level4", 32'(fifo_level), 32'd4);
        check("bp_count4", 32'(ev_count),   32'd4);
        aer_addr = 3'd4;
        aer_req  = 1'b1;
        repeat (8) tick();
        check("bp_no_ack", 32'(aer_ack),    32'd0);
        check("bp_full",   32'(fifo_level), 32'd4);
        check("bp_count",  32'(ev_count),   32'd4);
        ev_ready = 1'b1;
        check("bp_head0", 32'(ev_addr), 32'd0);
        tick();
        check("bp_full_pop_blocks", 32'(aer_ack),    32'd0);
        check("bp_level3",          32'(fifo_level), 32'd3);
        for (int k = 1; k < 5; k++) begin
            n = 0;
            while (!ev_valid && n < 10) begin
                tick();
                n++;
            end
            check("bp_order", 32'(ev_addr), 32'(k));
            tick();
        end
        aer_req = 1'b0;
        n = 0;
        while (aer_ack && n < 12) begin
            tick();
            n++;
        end
        check("bp_ack_fall", 32'(aer_ack),    32'd0);
        check("bp_empty",    32'(ev_valid),   32'd0);
        check("bp_count5",   32'(ev_count),   32'd5);

        // Push and pop on the same edge at level 2.
        do_reset();
        send_event(3'd5);
        send_event(3'd6);
        check("pp_level2", 32'(fifo_level), 32'd2);
        aer_addr = 3'd7;
        aer_req  = 1'b1;
        tick();
        tick();
        check("pp_head5", 32'(ev_addr), 32'd5);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pp_level_same", 32'(fifo_level), 32'd2);
        check("pp_ack",        32'(aer_ack),    32'd1);
        check("pp_head6",      32'(ev_addr),    32'd6);
        aer_req = 1'b0;
        n = 0;
        while (aer_ack && n < 12) begin
            tick();
            n++;
        end
        check("pp_ack_fall", 32'(aer_ack), 32'd0);
        ev_ready = 1'b1;
        check("pp_drain6", 32'(ev_addr), 32'd6);
        tick();
        check("pp_drain7", 32'(ev_addr), 32'd7);
        tick();
        check("pp_empty", 32'(ev_valid), 32'd0);

        // Stuck request: error after TIMEOUT clocks in WAIT_LO, ack held until req drops.
        do_reset();
        ev_ready = 1'b1;
        aer_addr = 3'd1;
        aer_req  = 1'b1;
        repeat (3) tick();
        check("to_ack", 32'(aer_ack), 32'd1);
        repeat (7) tick();
        check("to_err_early", 32'(err_timeout), 32'd0);
        repeat (10) tick();
        check("to_err_set",  32'(err_timeout), 32'd1);
        check("to_ack_held", 32'(aer_ack),     32'd1);
        aer_req = 1'b0;
        repeat (3) tick();
        check("to_ack_drop",   32'(aer_ack),     32'd0);
        check("to_err_sticky", 32'(err_timeout), 32'd1);

        // Reset in the middle of a handshake, request still high afterwards.
        do_reset();
        aer_addr = 3'd3;
        aer_req  = 1'b1;
        repeat (3) tick();
        check("mr_ack_before",   32'(aer_ack),    32'd1);
        check("mr_level_before", 32'(fifo_level), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_ack_async",   32'(aer_ack),     32'd0);
        check("mr_level_async", 32'(fifo_level),  32'd0);
        check("mr_valid_async", 32'(ev_valid),    32'd0);
        check("mr_count_async", 32'(ev_count),    32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("mr_ack_e2", 32'(aer_ack), 32'd0);
        tick();
        check("mr_ack_e3",  32'(aer_ack),  32'd1);
        check("mr_addr",    32'(ev_addr),  32'd3);
        check("mr_count1",  32'(ev_count), 32'd1);
        repeat (5) tick();
        check("mr_count_once", 32'(ev_count), 32'd1);
        aer_req = 1'b0;
        repeat (3) tick();
        check("mr_ack_drop", 32'(aer_ack), 32'd0);

        // Counter saturation with a 3-bit counter.
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_event(ADDR_W'(i));
        check("sat_count6", 32'(ev_count), 32'd6);
        send_event(3'd6);
        check("sat_count7", 32'(ev_count), 32'd7);
        for (int i = 0; i < 3; i++) send_event(ADDR_W'(i));
        check("sat_hold7", 32'(ev_count), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
